// File: rtl/reset_seq_pkg.sv
// Shared types and widths for the reset sequencer.
package reset_seq_pkg;

    localparam int CYCLE_W = 32;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        return (v == {CYCLE_W{1'b1}}) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchronizer; output is active-high.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic sync_reset
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift a deasserted level in from the bottom stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    // Synchronizer chain, forced asserted while reset_n is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_reset = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: synchronize, hold, then run with a cycle budget.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN (enables RUN->DONE timeout).
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int                 SYNC_STAGES = 2,
    parameter int                 HOLD_CYCLES = 4,
    parameter logic [CYCLE_W-1:0] MAX_CYCLES  = 32'd100
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               restart,
    output logic               reset,
    output logic               run_active,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic               sync_reset_s;
    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
    logic               timeout_q, timeout_d;
    logic               reset_q, reset_d;
    logic               run_active_q, run_active_d;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset_s)
    );

    // Next-state and next-output logic; outputs derive from the next state so they stay registered.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        case (state_q)
            SYNC: begin
                if (!sync_reset_s) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else begin
                    state_d = SYNC;
                end
            end
            HOLD: begin
                if (restart) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d       = RUN;
                    hold_cnt_d    = '0;
                    cycle_count_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (restart) begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
                end else if (cycle_count_q == (MAX_CYCLES - 32'd1)) begin
                    state_d       = DONE;
                    cycle_count_d = MAX_CYCLES;
                    timeout_d     = 1'b1;
`endif
                end else begin
                    cycle_count_d = sat_inc(cycle_count_q);
                end
            end
            DONE: begin
                if (restart) begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d       = SYNC;
                hold_cnt_d    = '0;
                cycle_count_d = '0;
                timeout_d     = 1'b0;
            end
        endcase
`ifndef RESET_SEQ_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        reset_d      = (state_d == SYNC) || (state_d == HOLD);
        run_active_d = (state_d == RUN);
    end

    // State and output registers, all forced to the reset condition while reset_n is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SYNC;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            reset_q       <= 1'b1;
            run_active_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            reset_q       <= reset_d;
            run_active_q  <= run_active_d;
        end
    end

    assign reset       = reset_q;
    assign run_active  = run_active_q;
    assign cycle_count = cycle_count_q;
    assign timeout     = timeout_q;

endmodule
